dp_read_ctrl: RTL and testbench

- Read-side (port B) controller for the team's dual-port word buffer.
- The write side commits one word per `wr_push` pulse. This block tracks how many committed words are unread, issues the read-enable and address to the buffer's synchronous read port, and presents each word on a valid/ready stream.
- It replaces hand-driven read-enable/increment sequencing with a self-timed drain engine.

---
 rtl/dp_read_ctrl_if.sv | 34 +++
 rtl/dp_read_ctrl.sv | 58 +++++
 tb/tb_dp_read_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dp_read_ctrl_if.sv
// dp_read_ctrl_if: buffer port-B / write-commit / output-stream bundle for dp_read_ctrl
//   wr_push      writer committed one word this cycle
//   rd_en        read strobe to buffer port B
//   rd_addr      read address to buffer port B
//   rd_data      buffer read data, one cycle after rd_en
//   out_data     stream data
//   out_valid    stream data valid
//   out_ready    downstream accepts on out_valid && out_ready
//   count        committed words not yet fetched
//   empty        count == 0
//   overflow_err sticky push-while-full flag
interface dp_read_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_push;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              overflow_err;
    modport master (
        input  wr_push, rd_data, out_ready,
        output rd_en, rd_addr, out_data, out_valid, count, empty, overflow_err
    );
    modport slave (
        output wr_push, rd_data, out_ready,
        input  rd_en, rd_addr, out_data, out_valid, count, empty, overflow_err
    );
endinterface

// File: rtl/dp_read_ctrl.sv
// dp_read_ctrl: self-timed drain engine for the read port of the dual-port word buffer
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  dp_read_ctrl_if master: push commits in, buffer read port out, valid/ready stream out
module dp_read_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic           clk,
    input logic           rst,
    dp_read_ctrl_if.master bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] VALID = 2'd2;
    logic [1:0]        state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] data_q;
    logic              ovf;
    logic              rd_en;
    logic              push_ok;
    always_comb begin
        rd_en   = cnt != '0 && (state == IDLE || (state == VALID && bus.out_ready));
        // a push while full is still legal when a fetch frees a slot in the same cycle
        push_ok = bus.wr_push && (cnt != FULL || rd_en);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rd_ptr <= '0;
            cnt    <= '0;
            data_q <= '0;
            ovf    <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + ADDR_W'(rd_en);
            if (push_ok != rd_en)
                cnt <= push_ok ? cnt + ONE : cnt - ONE;
            if (bus.wr_push && !push_ok)
                ovf <= 1'b1;
            state <= rd_en ? WAIT :
                     state == WAIT ? VALID :
                     (state == VALID && bus.out_ready) ? IDLE : state;
            if (state == WAIT)
                data_q <= bus.rd_data;
        end
    end
    assign bus.rd_en        = rd_en;
    assign bus.rd_addr      = rd_ptr;
    assign bus.out_data     = data_q;
    assign bus.out_valid    = state == VALID;
    assign bus.count        = cnt;
    assign bus.empty        = cnt == '0;
    assign bus.overflow_err = ovf;
endmodule

// File: tb/tb_dp_read_ctrl.sv
// tb_dp_read_ctrl: scoreboard bench for dp_read_ctrl with a behavioural buffer model
module tb_dp_read_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    dp_read_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    dp_read_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [7:0] mem [DEPTH];
    logic       wr_ok = 1'b0;
    logic [3:0] wr_ptr = '0;
    logic [7:0] wr_val = '0;
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
        if (wr_ok) mem[wr_ptr] <= wr_val;
    end
    int n_pass = 0;
    int n_tot = 0;
    logic [7:0] q[$];
    int mcnt = 0;
    logic [3:0] wp = '0;
    logic [3:0] ra = '0;
    logic [7:0] seq = '0;
    int cyc_n = 0;
    int vcyc[$];
    int ecyc[$];
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask
    task automatic monitor();
        chk("count", 32'(bus.count), mcnt);
        chk("empty", 32'(bus.empty), 32'(mcnt == 0));
        if (bus.rd_en) begin
            chk("rd_addr", 32'(bus.rd_addr), 32'(ra));
            chk("rd_en_nonempty", 32'(mcnt != 0), 32'd1);
            ra++;
            ecyc.push_back(cyc_n);
        end
        if (bus.out_valid) begin
            vcyc.push_back(cyc_n);
            if (bus.out_ready) begin
                if (q.size() == 0) chk("extra_word", q.size(), 32'd1);
                else chk("data", 32'(bus.out_data), 32'(q.pop_front()));
            end
        end
        wr_ok  = bus.wr_push && (mcnt < DEPTH || bus.rd_en);
        wr_ptr = wp;
        wr_val = 8'hA0 + seq;
        if (wr_ok) begin
            q.push_back(wr_val);
            wp++;
            seq++;
        end
        mcnt += int'(wr_ok) - int'(bus.rd_en);
        cyc_n++;
    endtask
    task automatic cyc(input logic p, input logic r);
        bus.wr_push   = p;
        bus.out_ready = r;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_model();
        q.delete();
        mcnt  = 0;
        wp    = '0;
        ra    = '0;
        seq   = '0;
        wr_ok = 1'b0;
    endtask
    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_push   = 1'($urandom);
            bus.out_ready = 1'($urandom);
            @(negedge clk);
            chk("rst_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_rden", 32'(bus.rd_en), 32'd0);
            chk("rst_addr", 32'(bus.rd_addr), 32'd0);
            chk("rst_count", 32'(bus.count), 32'd0);
            chk("rst_empty", 32'(bus.empty), 32'd1);
            chk("rst_ovf", 32'(bus.overflow_err), 32'd0);
            chk("rst_data", 32'(bus.out_data), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.wr_push   = 1'b0;
        bus.out_ready = 1'b0;
        clear_model();
        rst = 1'b1;
    endtask
    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            if (q.size() == 0 && !bus.out_valid && mcnt == 0) break;
            cyc(1'b0, 1'b1);
        end
        chk("drain_done", q.size(), 32'd0);
        chk("drain_idle", 32'(bus.out_valid), 32'd0);
    endtask
    initial begin
        int c0;
        bus.wr_push   = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        vcyc.delete();
        ecyc.delete();
        c0 = cyc_n;
        repeat (3) cyc(1'b1, 1'b1);
        repeat (8) cyc(1'b0, 1'b1);
        chk("basic_nvalid", vcyc.size(), 32'd3);
        chk("basic_nrden", ecyc.size(), 32'd3);
        if (vcyc.size() == 3 && ecyc.size() == 3) begin
            chk("basic_en_lat", ecyc[0] - c0, 32'd1);
            chk("basic_valid_lat", vcyc[0] - ecyc[0], 32'd2);
            chk("basic_space0", vcyc[1] - vcyc[0], 32'd2);
            chk("basic_space1", vcyc[2] - vcyc[1], 32'd2);
        end
        chk("basic_empty", 32'(bus.empty), 32'd1);
        chk("basic_last", 32'(bus.out_data), 32'hA2);
        do_reset();
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) break;
            cyc(1'b0, 1'b0);
        end
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0);
            chk("bp_data", 32'(bus.out_data), 32'hA0);
            chk("bp_rden", 32'(bus.rd_en), 32'd0);
            chk("bp_count", 32'(bus.count), 32'd1);
            chk("bp_valid_hold", 32'(bus.out_valid), 32'd1);
        end
        drain();
        chk("bp_second", 32'(bus.out_data), 32'hA1);
        do_reset();
        repeat (12) cyc(1'b1, 1'b1);
        drain();
        chk("sim_words", 32'(seq), 32'd12);
        do_reset();
        repeat (16) cyc(1'b1, 1'b0);
        chk("full_cnt15", 32'(bus.count), 32'd15);
        for (int i = 0; i < 4; i++) begin
            if (bus.count == 5'd16) break;
            cyc(1'b1, 1'b0);
        end
        chk("full_cnt16", 32'(bus.count), 32'd16);
        chk("full_no_ovf", 32'(bus.overflow_err), 32'd0);
        cyc(1'b1, 1'b0);
        chk("ovf_set", 32'(bus.overflow_err), 32'd1);
        chk("ovf_cnt", 32'(bus.count), 32'd16);
        drain();
        chk("ovf_sticky", 32'(bus.overflow_err), 32'd1);
        chk("wrap_words", 32'(seq), 32'd17);
        chk("wrap_addr", 32'(bus.rd_addr), 32'd1);
        do_reset();
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_count", 32'(bus.count), 32'd0);
        chk("mid_rden", 32'(bus.rd_en), 32'd0);
        chk("mid_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_addr", 32'(bus.rd_addr), 32'd0);
        chk("mid_empty", 32'(bus.empty), 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        clear_model();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1);
            chk("post_rden", 32'(bus.rd_en), 32'd0);
            chk("post_valid", 32'(bus.out_valid), 32'd0);
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end
endmodule
